// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and types for the interval timer slice.
//   CLK_FREQ_HZ_DEFAULT : default system clock frequency (Hz)
//   MODE_ONESHOT/PERIODIC : values of the interval_timer mode input
//   state_e             : interval FSM state encoding
package timer_pkg;

    localparam int unsigned CLK_FREQ_HZ_DEFAULT = 40_000_000;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock down to a base tick of TICK_HZ.
//   clk_40MHz : system clock
//   rst       : synchronous, active-high reset
//   enable    : prescaler counts while high, holds while low
//   clr       : forces the prescaler count back to 0 (resynchronise)
//   tick_int  : combinational strobe, high in the cycle before each tick edge
//   tick      : registered one-cycle tick pulse, every DIV cycles while enabled
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int unsigned TICK_HZ     = 1000
) (
    input  logic clk_40MHz,
    input  logic rst,
    input  logic enable,
    input  logic clr,
    output logic tick_int,
    output logic tick
);

    // Guarded so a bad TICK_HZ reaches the elaboration check instead of a divide-by-zero.
    localparam int unsigned DIV  = (TICK_HZ == 0) ? 0 : CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned REM  = (TICK_HZ == 0) ? 1 : CLK_FREQ_HZ % TICK_HZ;
    localparam int unsigned PW   = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'((DIV >= 2) ? DIV - 1 : 1);

    if (DIV < 2 || REM != 0) begin : g_bad_div
        $error("tick_prescaler: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q;

    assign tick_int = enable && (presc_q == LAST);
    assign tick     = tick_q;

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (enable) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_int;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// interval_timer: programmable one-shot/periodic interval counter on a base tick.
//   clk_40MHz      : system clock
//   rst            : synchronous, active-high reset
//   enable         : base-tick prescaler runs while high
//   start          : pulse; latch period/mode, clear elapsed, run (ignored if period==0)
//   stop           : pulse; pause, counters hold (no resume, next start reloads)
//   mode           : 0 one-shot, 1 periodic; sampled on start
//   period         : interval length in base ticks; sampled on start
//   one_milli_tick : registered base tick pulse
//   expire         : one-cycle pulse on interval completion, aligned with one_milli_tick
//   running        : interval counter active
//   elapsed        : ticks since last start, saturating
//   remaining      : ticks left in the current interval
module interval_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned RESYNC      = 0
) (
    input  logic             clk_40MHz,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    output logic             one_milli_tick,
    output logic             expire,
    output logic             running,
    output logic [CNT_W-1:0] elapsed,
    output logic [CNT_W-1:0] remaining
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             expire_q, expire_d;
    logic             tick_int;
    logic             load;
    logic             clr;

    assign load = start && (period != '0);
    assign clr  = (RESYNC != 0) && load;

    tick_prescaler #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TICK_HZ     (TICK_HZ)
    ) u_presc (
        .clk_40MHz (clk_40MHz),
        .rst       (rst),
        .enable    (enable),
        .clr       (clr),
        .tick_int  (tick_int),
        .tick      (one_milli_tick)
    );

    // Priority: start (valid period) > stop > tick. A stop on the expiring
    // tick therefore suppresses the expire and leaves remaining at 1.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        elapsed_d   = elapsed_q;
        period_d    = period_q;
        mode_d      = mode_q;
        expire_d    = 1'b0;
        if (load) begin
            period_d    = period;
            mode_d      = mode;
            remaining_d = period;
            elapsed_d   = '0;
            state_d     = RUN;
        end else if (stop) begin
            state_d = IDLE;
        end else if (state_q == RUN && tick_int) begin
            elapsed_d = (elapsed_q == '1) ? elapsed_q : elapsed_q + 1'b1;
            if (remaining_q > CNT_W'(1)) begin
                remaining_d = remaining_q - 1'b1;
            end else if (remaining_q == CNT_W'(1)) begin
                expire_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    remaining_d = period_q;
                end else begin
                    remaining_d = '0;
                    state_d     = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            elapsed_q   <= '0;
            period_q    <= '0;
            mode_q      <= MODE_ONESHOT;
            expire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            elapsed_q   <= elapsed_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            expire_q    <= expire_d;
        end
    end

    assign expire    = expire_q;
    assign running   = (state_q == RUN);
    assign elapsed   = elapsed_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: directed self-checking bench for interval_timer
// (DIV = 40000/1000 = 40, CNT_W = 8, RESYNC = 1, 25 ns clock).
`timescale 1ns/1ps
module tb_interval_timer;

    logic       clk = 1'b0;
    logic       rst, enable, start, stop, mode;
    logic [7:0] period;
    logic       one_milli_tick, expire, running;
    logic [7:0] elapsed, remaining;

    int n_cmp = 0;
    int n_mis = 0;

    always #12.5 clk = ~clk;

    interval_timer #(
        .CLK_FREQ_HZ (40000),
        .TICK_HZ     (1000),
        .CNT_W       (8),
        .RESYNC      (1)
    ) dut (
        .clk_40MHz      (clk),
        .rst            (rst),
        .enable         (enable),
        .start          (start),
        .stop           (stop),
        .mode           (mode),
        .period         (period),
        .one_milli_tick (one_milli_tick),
        .expire         (expire),
        .running        (running),
        .elapsed        (elapsed),
        .remaining      (remaining)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges; leaves time at 1 ns after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance n edges, counting tick and expire pulses seen.
    task automatic run_cycles(input int n, output int ticks, output int exps);
        ticks = 0;
        exps  = 0;
        repeat (n) begin
            step(1);
            ticks += int'(one_milli_tick);
            exps  += int'(expire);
        end
    endtask

    task automatic pulse_start(input logic [7:0] p, input logic m);
        period = p;
        mode   = m;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    initial begin
        int t, e;
        rst = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0;
        mode = 1'b0; period = '0;

        // 1: reset state and base tick timing
        step(3);
        check_eq("rst_tick", one_milli_tick, 0);
        check_eq("rst_expire", expire, 0);
        check_eq("rst_running", running, 0);
        check_eq("rst_elapsed", elapsed, 0);
        check_eq("rst_remaining", remaining, 0);
        rst = 1'b0;
        step(39);
        check_eq("t1_tick_c39", one_milli_tick, 0);
        step(1);
        check_eq("t1_tick_c40", one_milli_tick, 1);
        step(1);
        check_eq("t1_tick_c41", one_milli_tick, 0);
        step(38);
        check_eq("t1_tick_c79", one_milli_tick, 0);
        step(1);
        check_eq("t1_tick_c80", one_milli_tick, 1);
        check_eq("t1_running", running, 0);

        // 2: one-shot period 3, resynchronised -> expire 120 cycles after start
        pulse_start(8'd3, 1'b0);
        check_eq("t2_run_start", running, 1);
        check_eq("t2_rem_start", remaining, 3);
        check_eq("t2_el_start", elapsed, 0);
        step(119);
        check_eq("t2_exp_c119", expire, 0);
        check_eq("t2_rem_c119", remaining, 1);
        step(1);
        check_eq("t2_exp_c120", expire, 1);
        check_eq("t2_tick_c120", one_milli_tick, 1);
        check_eq("t2_run_c120", running, 0);
        check_eq("t2_rem_c120", remaining, 0);
        check_eq("t2_el_c120", elapsed, 3);
        run_cycles(200, t, e);
        check_eq("t2_no_more_exp", e, 0);

        // 3: periodic period 2 for 10 ticks
        pulse_start(8'd2, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(40);
            check_eq($sformatf("t3_tick_%0d", k), one_milli_tick, 1);
            check_eq($sformatf("t3_exp_%0d", k), expire, (k % 2 == 0) ? 1 : 0);
            check_eq($sformatf("t3_rem_%0d", k), remaining, (k % 2 == 0) ? 2 : 1);
            check_eq($sformatf("t3_el_%0d", k), elapsed, k);
        end
        check_eq("t3_running", running, 1);
        pulse_stop();

        // 4: pause after 2 ticks, then restart
        pulse_start(8'd5, 1'b0);
        step(80);
        check_eq("t4_rem_2t", remaining, 3);
        check_eq("t4_el_2t", elapsed, 2);
        pulse_stop();
        run_cycles(200, t, e);
        check_eq("t4_exp_paused", e, 0);
        check_eq("t4_run_paused", running, 0);
        check_eq("t4_rem_paused", remaining, 3);
        check_eq("t4_el_paused", elapsed, 2);
        pulse_start(8'd5, 1'b0);
        check_eq("t4_run_restart", running, 1);
        check_eq("t4_rem_restart", remaining, 5);
        check_eq("t4_el_restart", elapsed, 0);

        // 5a: start and stop together -> start wins
        pulse_stop();
        check_eq("t5a_stopped", running, 0);
        stop = 1'b1;
        pulse_start(8'd4, 1'b0);
        stop = 1'b0;
        check_eq("t5a_run", running, 1);
        check_eq("t5a_rem", remaining, 4);

        // 5b: stop on the expiring tick -> no expire, remaining stays 1
        pulse_start(8'd1, 1'b0);
        step(39);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("t5b_tick", one_milli_tick, 1);
        check_eq("t5b_exp", expire, 0);
        check_eq("t5b_rem", remaining, 1);
        check_eq("t5b_run", running, 0);
        run_cycles(100, t, e);
        check_eq("t5b_no_exp", e, 0);

        // 5c: start with period 0 is ignored (no reload, no resync)
        pulse_start(8'd3, 1'b0);
        step(40);
        check_eq("t5c_rem_1t", remaining, 2);
        pulse_start(8'd0, 1'b1);
        check_eq("t5c_run", running, 1);
        check_eq("t5c_rem", remaining, 2);
        check_eq("t5c_el", elapsed, 1);
        step(39);
        check_eq("t5c_rem_2t", remaining, 1);
        check_eq("t5c_el_2t", elapsed, 2);
        pulse_stop();

        // 6: saturation over 300 ticks, then freeze with enable low
        pulse_start(8'd255, 1'b1);
        run_cycles(12000, t, e);
        check_eq("t6_ticks", t, 300);
        check_eq("t6_exps", e, 1);
        check_eq("t6_el_sat", elapsed, 255);
        check_eq("t6_rem", remaining, 210);
        check_eq("t6_run", running, 1);
        enable = 1'b0;
        run_cycles(100, t, e);
        check_eq("t6_frozen_ticks", t, 0);
        check_eq("t6_frozen_exps", e, 0);
        check_eq("t6_frozen_el", elapsed, 255);
        check_eq("t6_frozen_rem", remaining, 210);
        enable = 1'b1;
        step(39);
        check_eq("t6_reen_c39", one_milli_tick, 0);
        step(1);
        check_eq("t6_reen_c40", one_milli_tick, 1);
        check_eq("t6_reen_rem", remaining, 209);

        // Reset mid-interval
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("t7_run", running, 0);
        check_eq("t7_rem", remaining, 0);
        check_eq("t7_el", elapsed, 0);
        check_eq("t7_exp", expire, 0);
        check_eq("t7_tick", one_milli_tick, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
